regfile_multiport: RTL and testbench

Parametrised successor to the 32x32 two-read/one-write register file: configurable data width, depth and number of combinational read ports, with register 0 hardwired to zero and a hardware bulk-clear engine. Sits in the CPU datapath between decode (read addresses) and writeback (write port). It is driven by the same style of self-checking bench the team uses for register files.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_clear_fsm.sv | 51 +++++
 rtl/regfile_multiport.sv | 65 ++++++
 tb/tb_regfile_multiport.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and default sizing for the multiport register file
package regfile_pkg;
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NREAD = 2;
endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: bulk-clear sequencer (IDLE/CLEAR), walks ptr 1..DEPTH-1 and flags writes dropped while busy
// Ports: Clk, Reset_n (async active-low), ClearReq, RegWrite in; Busy, ClearEn, ClearAddr, WriteDropped out
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          ClearReq,
    input  logic          RegWrite,
    output logic          Busy,
    output logic          ClearEn,
    output logic [AW-1:0] ClearAddr,
    output logic          WriteDropped
);
    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_ptr, w_ptr_nxt;
    logic          r_dropped;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_dropped <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_dropped <= RegWrite && (r_state == ST_CLEAR);
        end
    end

    // Entry 0 is hardwired to zero, so the sweep starts at 1 and ends on the last entry
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        if (r_state == ST_IDLE && ClearReq) begin
            w_state_nxt = ST_CLEAR;
            w_ptr_nxt   = AW'(1);
        end else if (r_state == ST_CLEAR) begin
            w_ptr_nxt   = r_ptr + AW'(1);
            w_state_nxt = (r_ptr == AW'(DEPTH - 1)) ? ST_IDLE : ST_CLEAR;
        end
    end

    assign Busy         = (r_state == ST_CLEAR);
    assign ClearEn      = Busy;
    assign ClearAddr    = r_ptr;
    assign WriteDropped = r_dropped;
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: WIDTH x DEPTH register file, NREAD combinational read ports, reg 0 reads zero, hardware bulk clear
// Ports: Clk, Reset_n (async active-low), RegWrite/WriteRegister/WriteData write port, ReadRegister/ReadData packed
//        read ports, ClearReq starts a clear, Busy while clearing, WriteDropped pulses after a write rejected while Busy.
// Optional: REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NREAD = DEF_NREAD,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   RegWrite,
    input  logic [AW-1:0]          WriteRegister,
    input  logic [WIDTH-1:0]       WriteData,
    input  logic [NREAD*AW-1:0]    ReadRegister,
    output logic [NREAD*WIDTH-1:0] ReadData,
    input  logic                   ClearReq,
    output logic                   Busy,
    output logic                   WriteDropped
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_clr_en;
    logic [AW-1:0]    w_clr_addr;
    logic             w_we;

    regfile_clear_fsm #(.DEPTH(DEPTH)) u_clear_fsm (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .ClearReq     (ClearReq),
        .RegWrite     (RegWrite),
        .Busy         (Busy),
        .ClearEn      (w_clr_en),
        .ClearAddr    (w_clr_addr),
        .WriteDropped (WriteDropped)
    );

    assign w_we = RegWrite && !Busy && (WriteRegister != '0);

    // Clear and write never coincide: a write is only accepted while not Busy
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_mem <= '{default: '0};
        end else if (w_clr_en) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_we) begin
            r_mem[WriteRegister] <= WriteData;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]    w_raddr;
        logic [WIDTH-1:0] w_rdata;
        assign w_raddr = ReadRegister[k*AW +: AW];
        assign w_rdata = (w_raddr == '0) ? '0 : r_mem[w_raddr];
`ifdef REGFILE_BYPASS_EN
        // w_we already excludes address 0 and the clear window
        assign ReadData[k*WIDTH +: WIDTH] = (w_we && w_raddr == WriteRegister) ? WriteData : w_rdata;
`else
        assign ReadData[k*WIDTH +: WIDTH] = w_rdata;
`endif
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: scoreboard bench for regfile_multiport with four read ports
module tb_regfile_multiport;
  localparam int W  = 32;
  localparam int D  = 32;
  localparam int N  = 4;
  localparam int AW = 5;
  localparam logic [31:0] PAT = 32'hA5A5A5A5;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            we = 1'b0;
  logic            clr = 1'b0;
  logic [AW-1:0]   wa = '0;
  logic [W-1:0]    wd = '0;
  logic [N*AW-1:0] ra = '0;
  logic [N*W-1:0]  rd;
  logic            busy;
  logic            drop;
  typedef struct {
    int          kind;
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;
  exp_t        q[$];
  exp_t        m_e;
  logic [31:0] m_act;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_wait;
  always #5 clk = ~clk;
  regfile_multiport #(.WIDTH(W), .DEPTH(D), .NREAD(N)) dut (
    .Clk           (clk),
    .Reset_n       (rst_n),
    .RegWrite      (we),
    .WriteRegister (wa),
    .WriteData     (wd),
    .ReadRegister  (ra),
    .ReadData      (rd),
    .ClearReq      (clr),
    .Busy          (busy),
    .WriteDropped  (drop)
  );
  always @(negedge clk) begin
    while (q.size() > 0) begin
      m_e = q.pop_front();
      m_act = (m_e.kind == 0) ? rd[m_e.port*W +: W] : (m_e.kind == 1) ? 32'(busy) : 32'(drop);
      n_checks++;
      if (m_act !== m_e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", m_e.name, m_act, m_e.exp);
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_rd(input int k, input int a);
    ra[k*AW +: AW] = AW'(a);
  endtask
  task automatic exp_rd(input int k, input logic [31:0] v, input string name);
    q.push_back('{0, k, v, name});
  endtask
  task automatic exp_busy(input logic v, input string name);
    q.push_back('{1, 0, 32'(v), name});
  endtask
  task automatic exp_drop(input logic v, input string name);
    q.push_back('{2, 0, 32'(v), name});
  endtask
  task automatic write(input int a, input logic [31:0] v);
    we = 1'b1;
    wa = AW'(a);
    wd = v;
    cyc();
    we = 1'b0;
  endtask
  task automatic read_all(input logic [31:0] v, input string name);
    for (int b = 0; b < D; b += N) begin
      for (int k = 0; k < N; k++) begin
        set_rd(k, b + k);
        exp_rd(k, (b + k == 0) ? 32'h0 : v, name);
      end
      cyc();
    end
  endtask
  initial begin
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || drop !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy %b drop %b", busy, drop);
    end
    exp_busy(1'b0, "reset_busy");
    exp_drop(1'b0, "reset_drop");
    read_all(32'h0, "reset_read");
    write(2, 42);
    set_rd(0, 2);
    set_rd(1, 2);
    exp_rd(0, 42, "wr42_p0");
    exp_rd(1, 42, "wr42_p1");
    cyc();
    write(2, 15);
    exp_rd(0, 15, "wr15_p0");
    exp_rd(1, 15, "wr15_p1");
    cyc();
    write(0, 32'hDEADBEEF);
    set_rd(0, 0);
    exp_rd(0, 0, "reg0_zero");
    exp_drop(1'b0, "reg0_no_drop");
    cyc();
    for (int i = 1; i < D; i++) write(i, i);
    set_rd(0, 3);
    set_rd(1, 7);
    set_rd(2, 17);
    set_rd(3, 31);
    exp_rd(0, 3, "multi_r3");
    exp_rd(1, 7, "multi_r7");
    exp_rd(2, 17, "multi_r17");
    exp_rd(3, 31, "multi_r31");
    cyc();
    for (int i = 1; i < D; i++) write(i, PAT);
    clr = 1'b1;
    cyc();
    for (int c = 0; c <= 31; c++) begin
      we  = (c == 4) || (c == 10) || (c == 12);
      wa  = (c == 4) ? AW'(20) : (c == 10) ? AW'(5) : AW'(0);
      wd  = 99;
      clr = (c == 20);
      set_rd(0, 1);
      set_rd(1, 31);
      set_rd(2, 20);
      set_rd(3, (c < 31) ? c + 1 : 0);
      exp_busy(c < 31, "busy_window");
      exp_drop((c == 5) || (c == 11) || (c == 13), "drop_pulse");
      if (c >= 1) begin
        exp_rd(0, 0, "clr_r1_zero");
        exp_rd(1, (c < 31) ? PAT : 32'h0, "clr_r31");
        exp_rd(2, (c < 20) ? PAT : 32'h0, "clr_r20_no_write");
        if (c <= 30) exp_rd(3, PAT, "clr_next_pending");
      end
      cyc();
    end
    we  = 1'b0;
    clr = 1'b0;
    read_all(32'h0, "after_clear");
    write(9, 32'h1234);
    write(30, 32'h5678);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    set_rd(0, 9);
    set_rd(1, 30);
    exp_busy(1'b0, "rst_mid_busy");
    exp_rd(0, 0, "rst_mid_r9");
    exp_rd(1, 0, "rst_mid_r30");
    cyc();
    rst_n = 1'b1;
    exp_busy(1'b0, "rst_release_idle");
    cyc();
    exp_busy(1'b0, "rst_stay_idle");
    read_all(32'h0, "after_rst");
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    n_wait = 0;
    while (busy && n_wait < 40) begin
      cyc();
      n_wait++;
    end
    n_checks++;
    if (busy !== 1'b0 || n_wait != D - 1) begin
      n_fail++;
      $display("FAIL clear_wait: busy %b after %0d cycles, expected %0d", busy, n_wait, D - 1);
    end
    write(4, 7);
    we = 1'b1;
    wa = 4;
    wd = 8;
    set_rd(0, 4);
    set_rd(1, 0);
`ifdef REGFILE_BYPASS_EN
    exp_rd(0, 8, "bypass_same_cycle");
`else
    exp_rd(0, 7, "no_bypass_same_cycle");
`endif
    exp_rd(1, 0, "bypass_reg0");
    cyc();
    we = 1'b0;
    exp_rd(0, 8, "bypass_after_edge");
    cyc();
    write(0, 5);
    we = 1'b1;
    wa = 0;
    wd = 5;
    set_rd(1, 0);
    exp_rd(1, 0, "bypass_addr0_blocked");
    cyc();
    we = 1'b0;
    cyc();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
